// File: rtl/psma_out_accum_pkg.sv
//==== psma_out_accum_pkg | FSM states, accumulator type and lane sign-extension helper
//==== rev 1.0
`default_nettype none

package psma_out_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int PSMA_ACC_W = 32;
  typedef logic signed [PSMA_ACC_W-1:0] acc_t;

  // Left-justify the lane, then arithmetic-shift back so bit lane_w-1 fills the top.
  function automatic logic [63:0] sign_ext(input logic [63:0] value, input logic [7:0] lane_w);
    logic [6:0] sh;
    sh = 7'(8'd64 - lane_w);
    return $unsigned($signed(value << sh) >>> sh);
  endfunction

endpackage

`default_nettype wire

// File: rtl/psma_lane_acc.sv
//==== psma_lane_acc | one lane: sign-extend, accumulate, detect overflow (PSMA_ACC_SAT_EN: saturate)
//==== rev 1.0
`default_nettype none

module psma_lane_acc
  import psma_out_accum_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int ACC_W = 32,
  parameter int LW_W  = $clog2(IN_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  slot_i,
  input  logic [LW_W-1:0]  lane_w_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_result;
  logic             w_ovf;

  assign w_addend = ACC_W'(sign_ext(64'(slot_i), 8'(lane_w_i)));
  assign w_sum    = acc_q + w_addend;
  assign w_ovf    = (acc_q[ACC_W-1] == w_addend[ACC_W-1]) && (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef PSMA_ACC_SAT_EN
  // On overflow both operands share a sign, so the clamp direction follows acc_q.
  assign w_result = !w_ovf ? w_sum :
                    acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_result = w_sum;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = en_i && w_ovf;

endmodule

`default_nettype wire

// File: rtl/psma_out_accum.sv
//==== psma_out_accum | accumulate MAC-array partial sums over a tile, then drain one lane per cycle
//==== rev 1.0 -- PSMA_ACC_SAT_EN selects saturating (defined) or wrapping (undefined) lanes
`default_nettype none

module psma_out_accum
  import psma_out_accum_pkg::*;
#(
  parameter int MAX_OUTS = 64,
  parameter int IN_W     = 32,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(MAX_OUTS):0]  cfg_n_outs,
  input  logic [$clog2(IN_W):0]      cfg_lane_w,
  input  logic [LEN_W-1:0]           cfg_acc_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAX_OUTS*IN_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);

  localparam int c_nw = $clog2(MAX_OUTS) + 1;
  localparam int c_lw = $clog2(IN_W) + 1;
  localparam int c_pw = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

  state_e           state_q, state_d;
  logic [c_nw-1:0]  n_outs_q, n_outs_d;
  logic [c_lw-1:0]  lane_w_q, lane_w_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [c_pw-1:0]  ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic                w_beat;
  logic                w_clr;
  logic                w_last;
  logic [MAX_OUTS-1:0] w_lane_ovf;
  logic [ACC_W-1:0]    w_acc [MAX_OUTS];

  assign w_beat = (state_q == ST_ACCUM) && in_valid;
  assign w_last = (c_nw'(ptr_q) == (n_outs_q - 1'b1));

  generate
    for (genvar gi = 0; gi < MAX_OUTS; gi++) begin : g_lane
      psma_lane_acc #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .LW_W  (c_lw)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_clr),
        .en_i     (w_beat && (c_nw'(gi) < n_outs_q)),
        .slot_i   (in_data[gi*IN_W +: IN_W]),
        .lane_w_i (lane_w_q),
        .acc_o    (w_acc[gi]),
        .ovf_o    (w_lane_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    n_outs_d = n_outs_q;
    lane_w_d = lane_w_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    w_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_outs_d = cfg_n_outs;
          lane_w_d = cfg_lane_w;
          len_d    = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
          cnt_d    = '0;
          ptr_d    = '0;
          ovf_d    = 1'b0;
          w_clr    = 1'b1;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q || (|w_lane_ovf);
          if ((cnt_q + 1'b1) == len_q) begin
            ptr_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (w_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_outs_q <= '0;
      lane_w_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_outs_q <= n_outs_d;
      lane_w_q <= lane_w_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? w_acc[ptr_q] : '0;
  assign out_last  = out_valid && w_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_psma_out_accum.sv
//==== tb_psma_out_accum | randomized + directed self-checking bench for psma_out_accum
//==== rev 1.0
`default_nettype none

module tb_psma_out_accum;

  localparam int MO = 64;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [6:0]     cfg_n_outs = '0;
  logic [5:0]     cfg_lane_w = '0;
  logic [LW-1:0]  cfg_acc_len = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [MO*IW-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  out_data;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           ovf;

  psma_out_accum #(.MAX_OUTS(MO), .IN_W(IW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_n_outs(cfg_n_outs), .cfg_lane_w(cfg_lane_w), .cfg_acc_len(cfg_acc_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  longint exp_q[$];
  int     got_q[$];
  bit     exp_ovf = 1'b0;
  bit     exp_done = 1'b0;
  int     hs_count = 0;
  int     valid_cycles = 0;

  longint macc [MO];
  bit     movf;
  logic [IW-1:0] fixed_slot [MO];

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic longint sext(input longint v, input int lw);
    longint m;
    longint r;
    m = (64'sd1 <<< lw) - 64'sd1;
    r = v & m;
    if (((r >>> (lw - 1)) & 64'sd1) != 0) r = r - (64'sd1 <<< lw);
    return r;
  endfunction

  // Reference: exact integer sum per beat, then wrap or clamp to the signed ACC_W range.
  function automatic void model_add(input int i, input longint s);
    longint t;
    t = macc[i] + s;
    if (t > MAXV || t < MINV) begin
      movf = 1'b1;
`ifdef PSMA_ACC_SAT_EN
      t = (t > MAXV) ? MAXV : MINV;
`else
      t = (t > MAXV) ? t - (64'sd1 <<< 32) : t + (64'sd1 <<< 32);
`endif
    end
    macc[i] = t;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      chk("done", done, exp_done);
      exp_done = 1'b0;
      if (out_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_valid, 0);
        end else begin
          chk("out_data", $signed(out_data), exp_q[0]);
          chk("out_last", out_last, (exp_q.size() == 1) ? 1 : 0);
          chk("ovf", ovf, exp_ovf);
          if (out_ready) begin
            got_q.push_back(int'($signed(out_data)));
            hs_count++;
            if (exp_q.size() == 1) exp_done = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  task automatic fill_data(input bit fixed, input int n);
    for (int i = 0; i < MO; i++) begin
      in_data[i*IW +: IW] = (fixed && i < n) ? fixed_slot[i] : IW'($urandom);
    end
  endtask

  task automatic run_tile(input int n, input int lw, input int len, input bit fixed,
                          input int rdy_mode, input bit bad_start, input int rst_after);
    int beats;
    int gaps;
    int cyc;
    beats = (len == 0) ? 1 : len;
    for (int i = 0; i < MO; i++) macc[i] = 0;
    movf = 1'b0;
    got_q.delete();
    hs_count = 0;
    valid_cycles = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_n_outs = 7'(n);
    cfg_lane_w = 6'(lw);
    cfg_acc_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_n_outs = 7'($urandom_range(1, MO));
    cfg_lane_w = 6'($urandom_range(4, IW));
    cfg_acc_len = LW'($urandom);
    chk("busy_after_start", busy, 1);
    for (int b = 0; b < beats; b++) begin
      gaps = bad_start ? 1 : (fixed ? (b % 2) : $urandom_range(0, 2));
      repeat (gaps) begin
        in_valid = 1'b0;
        fill_data(1'b0, 0);
        if (bad_start) begin
          start = 1'b1;
          cfg_n_outs = 7'd1;
          cfg_lane_w = 6'd4;
          cfg_acc_len = LW'(9);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      fill_data(fixed, n);
      in_valid = 1'b1;
      chk("in_ready", in_ready, 1);
      for (int i = 0; i < n; i++) model_add(i, sext(longint'(in_data[i*IW +: IW]), lw));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(macc[i]);
    exp_ovf = movf;
    chk("in_ready_after_last", in_ready, 0);
    cyc = 0;
    while (busy && cyc < 1000) begin
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc >= 3);
      endcase
      if (rst_after > 0 && hs_count == rst_after) begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_out_valid", out_valid, 0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 1000) chk("drain_timeout", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic accumulation: junk above bit 15 must be ignored.
    fixed_slot[0] = 32'hABCD0005;
    fixed_slot[1] = 32'h1234FFFE;
    fixed_slot[2] = 32'h00000064;
    fixed_slot[3] = 32'hFFFF8000;
    run_tile(4, 16, 3, 1'b1, 0, 1'b0, 0);
    chk("basic_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("basic_w0", got_q[0], 15);
      chk("basic_w1", got_q[1], -6);
      chk("basic_w2", got_q[2], 300);
      chk("basic_w3", got_q[3], -98304);
    end

    fixed_slot[0] = 32'h0000000F;
    run_tile(1, 4, 1, 1'b1, 0, 1'b0, 0);
    chk("sext_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("sext_w0", got_q[0], -1);
    run_tile(1, 4, 0, 1'b1, 1, 1'b0, 0);
    chk("len0_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("len0_w0", got_q[0], -1);

    run_tile(2, 16, 1, 1'b0, 2, 1'b0, 0);
    chk("bp_drain_cycles", valid_cycles, 5);

    fixed_slot[0] = 32'h7FFFFFFF;
    run_tile(1, 32, 2, 1'b1, 0, 1'b0, 0);
    chk("ovf_count", got_q.size(), 1);
`ifdef PSMA_ACC_SAT_EN
    if (got_q.size() == 1) chk("ovf_w0", got_q[0], 2147483647);
`else
    if (got_q.size() == 1) chk("ovf_w0", got_q[0], -2);
`endif
    chk("ovf_sticky", ovf, 1);

    for (int i = 0; i < 3; i++) fixed_slot[i] = IW'(32'h00000081 + i);
    run_tile(3, 8, 4, 1'b1, 1, 1'b1, 0);
    chk("ignored_start_count", got_q.size(), 3);
    if (got_q.size() == 3) chk("ignored_start_w0", got_q[0], -508);

    run_tile(8, 12, 2, 1'b0, 0, 1'b0, 1);
    chk("rst_words_seen", got_q.size(), 1);
    run_tile(8, 12, 2, 1'b0, 0, 1'b0, 0);
    chk("after_rst_count", got_q.size(), 8);

    for (int t = 0; t < 12; t++) begin
      run_tile($urandom_range(1, MO), $urandom_range(4, IW), $urandom_range(0, 5),
               1'b0, $urandom_range(0, 1), 1'b0, 0);
    end
    run_tile(MO, IW, 3, 1'b0, 1, 1'b0, 0);
    chk("full_width_count", got_q.size(), MO);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
